// File: rtl/mem_io_router_if.sv
// Bus bundle between the CPU memory port, the SDRAM mem_driver and the
// memory-mapped I/O pins handled by mem_io_router.
//
// Handshake: a request (mem_r_en or mem_w_en) is taken on a rising edge only
// while mem_rdy is high; otherwise it is dropped, not queued. Each taken
// request produces exactly one single-cycle mem_cplt, with mem_data_out valid
// in that cycle. On the DRAM side dram_r_en/dram_w_en are single-cycle
// strobes issued only while dram_rdy is high, and dram_cplt marks completion.
interface mem_io_router_if #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int IO_OUT_COUNT = 4,
  parameter int IO_IN_COUNT  = 2
) ();
  // io_in keeps at least one word so a design with no input ports still has
  // a legal vector width.
  localparam int IN_W = ((IO_IN_COUNT > 0) ? IO_IN_COUNT : 1) * DATA_WIDTH;

  logic [ADDR_WIDTH-1:0]              mem_addr;
  logic [DATA_WIDTH-1:0]              mem_data_in;
  logic                               mem_r_en;
  logic                               mem_w_en;
  logic                               mem_rdy;
  logic                               mem_cplt;
  logic [DATA_WIDTH-1:0]              mem_data_out;
  logic                               dram_r_en;
  logic                               dram_w_en;
  logic                               dram_rdy;
  logic                               dram_cplt;
  logic [DATA_WIDTH-1:0]              dram_data_out;
  logic [IO_OUT_COUNT*DATA_WIDTH-1:0] io_out;
  logic [IO_OUT_COUNT-1:0]            io_wr_stb;
  logic [IN_W-1:0]                    io_in;

  // Router side.
  modport slave (
    input  mem_addr, mem_data_in, mem_r_en, mem_w_en,
    input  dram_rdy, dram_cplt, dram_data_out, io_in,
    output mem_rdy, mem_cplt, mem_data_out,
    output dram_r_en, dram_w_en, io_out, io_wr_stb
  );

  // CPU / memory-driver / pin side.
  modport master (
    output mem_addr, mem_data_in, mem_r_en, mem_w_en,
    output dram_rdy, dram_cplt, dram_data_out, io_in,
    input  mem_rdy, mem_cplt, mem_data_out,
    input  dram_r_en, dram_w_en, io_out, io_wr_stb
  );
endinterface

// File: rtl/mem_io_router.sv
// Memory request router: decodes each accepted CPU request against an I/O
// window of R/W output registers followed by read-only input ports, and
// forwards everything else to the SDRAM driver. One transaction in flight.
module mem_io_router #(
  parameter int                ADDR_WIDTH   = 16,
  parameter int                DATA_WIDTH   = 16,
  parameter logic [31:0]       IO_BASE      = 32'h0100,
  parameter int                IO_OUT_COUNT = 4,
  parameter int                IO_IN_COUNT  = 2,
  parameter logic [31:0]       IO_RESET_VAL = 32'h0100
) (
  input  logic              clk,
  input  logic              rst,
  mem_io_router_if.slave    bus,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DRAM_WAIT = 2'd1,
    IO_RESP   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(IO_BASE);
  localparam logic [ADDR_WIDTH-1:0] OUT_A   = ADDR_WIDTH'(IO_OUT_COUNT);
  localparam logic [ADDR_WIDTH-1:0] END_A   = ADDR_WIDTH'(IO_OUT_COUNT + IO_IN_COUNT);
  localparam logic [DATA_WIDTH-1:0] RESET_W = DATA_WIDTH'(IO_RESET_VAL);

  state_t                             state_q, state_d;
  logic [IO_OUT_COUNT*DATA_WIDTH-1:0] io_out_q;
  logic [IO_OUT_COUNT-1:0]            wr_stb_q;
  logic [DATA_WIDTH-1:0]              resp_q;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  above_base, out_hit, in_hit, io_hit;
  logic                  accept, is_read, io_wr_en;
  logic                  mem_rdy, mem_cplt, dram_r_en, dram_w_en;
  logic [DATA_WIDTH-1:0] mem_data_out, rd_val;

  // Address decode: the offset wraps for addresses below the base, so the
  // explicit above_base term keeps those out of the window.
  assign offset     = bus.mem_addr - BASE_A;
  assign above_base = (bus.mem_addr >= BASE_A);
  assign out_hit    = above_base && (offset < OUT_A);
  assign in_hit     = above_base && (offset >= OUT_A) && (offset < END_A);
  assign io_hit     = out_hit || in_hit;

  // Read wins when both enables are high, so a write only happens alone.
  assign mem_rdy  = (state_q == IDLE) && bus.dram_rdy;
  assign accept   = mem_rdy && (bus.mem_r_en || bus.mem_w_en);
  assign is_read  = bus.mem_r_en;
  assign io_wr_en = accept && !is_read && out_hit;

  // Select the I/O word addressed by the current offset for a read.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < IO_OUT_COUNT; k++) begin
      if (offset == ADDR_WIDTH'(k)) rd_val = io_out_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int j = 0; j < IO_IN_COUNT; j++) begin
      if (offset == ADDR_WIDTH'(IO_OUT_COUNT + j)) rd_val = bus.io_in[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic plus the completion and DRAM strobe outputs.
  always_comb begin
    state_d      = state_q;
    mem_cplt     = 1'b0;
    mem_data_out = '0;
    dram_r_en    = 1'b0;
    dram_w_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (io_hit) begin
            state_d = IO_RESP;
          end else begin
            state_d   = DRAM_WAIT;
            dram_r_en = is_read;
            dram_w_en = !is_read;
          end
        end
      end
      DRAM_WAIT: begin
        mem_cplt     = bus.dram_cplt;
        mem_data_out = bus.dram_data_out;
        if (bus.dram_cplt) state_d = IDLE;
      end
      IO_RESP: begin
        mem_cplt     = 1'b1;
        mem_data_out = resp_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output registers load at the accept edge; the strobe follows for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io_out_q <= {IO_OUT_COUNT{RESET_W}};
      wr_stb_q <= '0;
    end else begin
      wr_stb_q <= '0;
      for (int k = 0; k < IO_OUT_COUNT; k++) begin
        if (io_wr_en && (offset == ADDR_WIDTH'(k))) begin
          io_out_q[k*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_data_in;
          wr_stb_q[k]                          <= 1'b1;
        end
      end
    end
  end

  // I/O response word: read data captured at accept, zero for writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_q <= '0;
    end else if (accept && io_hit) begin
      resp_q <= is_read ? rd_val : '0;
    end
  end

  assign bus.mem_rdy      = mem_rdy;
  assign bus.mem_cplt     = mem_cplt;
  assign bus.mem_data_out = mem_data_out;
  assign bus.dram_r_en    = dram_r_en;
  assign bus.dram_w_en    = dram_w_en;
  assign bus.io_out       = io_out_q;
  assign bus.io_wr_stb    = wr_stb_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_mem_io_router.sv
// Randomized scoreboard bench for mem_io_router: a driver issues requests and
// plays the SDRAM driver, a monitor compares every cycle against a model.
module tb_mem_io_router;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int NOUT = 4;
  localparam int NIN  = 2;
  localparam int BASE = 'h0100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_io_router_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IO_OUT_COUNT(NOUT), .IO_IN_COUNT(NIN)) bus ();
  logic [1:0] state_dbg;

  mem_io_router #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IO_BASE(32'h0100),
    .IO_OUT_COUNT(NOUT), .IO_IN_COUNT(NIN), .IO_RESET_VAL(32'h0100)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_o(state_dbg)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0]      exp_q[$];
  logic [DW-1:0]      model_out[NOUT];
  logic               busy       = 1'b0;
  logic               exp_dram_r = 1'b0;
  logic               exp_dram_w = 1'b0;
  logic [NOUT-1:0]    exp_stb    = '0;
  int                 n_cmp = 0;
  int                 n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NOUT*DW-1:0] model_packed();
    logic [NOUT*DW-1:0] v;
    for (int k = 0; k < NOUT; k++) v[k*DW +: DW] = model_out[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NOUT; k++) model_out[k] = 16'h0100;
    exp_q.delete();
    busy = 1'b0; exp_dram_r = 1'b0; exp_dram_w = 1'b0; exp_stb = '0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk); #2;
      chk("mem_rdy",   {63'd0, bus.mem_rdy},   {63'd0, (!busy && bus.dram_rdy)});
      chk("dram_r_en", {63'd0, bus.dram_r_en}, {63'd0, exp_dram_r});
      chk("dram_w_en", {63'd0, bus.dram_w_en}, {63'd0, exp_dram_w});
      chk("io_wr_stb", {60'd0, bus.io_wr_stb}, {60'd0, exp_stb});
      chk("io_out",    bus.io_out,             model_packed());
      if (!busy) chk("idle_out", {47'd0, bus.mem_cplt, bus.mem_data_out}, 64'd0);
      if (bus.mem_cplt) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cplt", {63'd0, bus.mem_cplt}, 64'd0);
        end else begin
          chk("rdata", {48'd0, bus.mem_data_out}, {48'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_bus();
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
    bus.mem_addr = '0;   bus.mem_data_in = '0;
  endtask

  // One full request; plays the SDRAM driver with latency lat for DRAM hits.
  task automatic do_req(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic r, input logic w,
                        input logic [DW-1:0] rsp, input int lat);
    int off;
    bit out_hit, in_hit;
    logic [DW-1:0] expv;
    @(negedge clk);
    bus.dram_rdy = 1'b1;
    if ($urandom_range(0, 3) == 0) bus.io_in = {$urandom, $urandom};
    off     = int'(addr) - BASE;
    out_hit = (off >= 0) && (off < NOUT);
    in_hit  = (off >= NOUT) && (off < NOUT + NIN);
    bus.mem_addr = addr; bus.mem_data_in = wdata;
    bus.mem_r_en = r;    bus.mem_w_en = w;
    exp_dram_r = !(out_hit || in_hit) && r;
    exp_dram_w = !(out_hit || in_hit) && w && !r;
    @(posedge clk); #1;
    idle_bus();
    exp_dram_r = 1'b0; exp_dram_w = 1'b0;
    busy = 1'b1;
    if (out_hit || in_hit) begin
      expv = '0;
      if (r) expv = out_hit ? model_out[off] : bus.io_in[(off - NOUT)*DW +: DW];
      else if (out_hit) begin
        model_out[off] = wdata;
        exp_stb = NOUT'(1) << off;
      end
      exp_q.push_back(expv);
      @(posedge clk); #1;
      chk("io_latency", 64'(exp_q.size()), 64'd0);
      busy = 1'b0; exp_stb = '0;
    end else begin
      exp_q.push_back(rsp);
      for (int i = 0; i <= lat; i++) begin
        @(negedge clk);
        if (i == lat) begin
          idle_bus();
          bus.dram_cplt = 1'b1; bus.dram_data_out = rsp;
        end else begin
          // Requests while busy must be ignored.
          bus.dram_data_out = 16'($urandom);
          bus.mem_addr  = AW'(BASE + $urandom_range(0, 7));
          bus.mem_data_in = 16'($urandom);
          bus.mem_r_en  = 1'($urandom_range(0, 1));
          bus.mem_w_en  = 1'($urandom_range(0, 1));
        end
      end
      @(posedge clk); #1;
      bus.dram_cplt = 1'b0;
      chk("dram_cplt_seen", 64'(exp_q.size()), 64'd0);
      busy = 1'b0;
    end
  endtask

  // A write pulse while dram_rdy is low must not be accepted.
  task automatic ignored_pulse(input logic [AW-1:0] addr);
    @(negedge clk);
    bus.dram_rdy = 1'b0;
    bus.mem_addr = addr; bus.mem_data_in = 16'($urandom);
    bus.mem_w_en = 1'b1; bus.mem_r_en = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    idle_bus();
    bus.dram_rdy = 1'b1;
  endtask

  // Reset in the middle of a DRAM read; the late completion must vanish.
  task automatic reset_mid_dram();
    @(negedge clk);
    bus.mem_addr = 16'h0200; bus.mem_r_en = 1'b1;
    exp_dram_r = 1'b1;
    @(posedge clk); #1;
    idle_bus(); exp_dram_r = 1'b0; busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.dram_cplt = 1'b1; bus.dram_data_out = 16'hCAFE;
    @(negedge clk);
    bus.dram_cplt = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [AW-1:0] a;
    int sel;
    idle_bus();
    bus.dram_rdy = 1'b1; bus.dram_cplt = 1'b0; bus.dram_data_out = '0;
    bus.io_in = {16'h1234, 16'h5678};
    model_reset();
    repeat (2) @(negedge clk);
    bus.dram_rdy = 1'b0;
    @(negedge clk);
    bus.dram_rdy = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed scenarios.
    do_req(16'h0102, 16'hBEEF, 1'b0, 1'b1, 16'h0, 0);
    do_req(16'h0102, 16'h0,    1'b1, 1'b0, 16'h0, 0);
    @(negedge clk); bus.io_in = {16'h1234, 16'h5678};
    do_req(16'h0105, 16'h0,    1'b1, 1'b0, 16'h0, 0);
    do_req(16'h0105, 16'h7777, 1'b0, 1'b1, 16'h0, 0);
    do_req(16'h0200, 16'h0,    1'b1, 1'b0, 16'hCAFE, 3);
    do_req(16'h00FF, 16'h0,    1'b1, 1'b0, 16'hCAFE, 2);
    do_req(16'h0106, 16'h1111, 1'b0, 1'b1, 16'h2222, 1);
    do_req(16'h0101, 16'hDEAD, 1'b1, 1'b1, 16'h0, 0);
    ignored_pulse(16'h0101);
    ignored_pulse(16'h0300);
    do_req(16'h0103, 16'hA5A5, 1'b0, 1'b1, 16'h0, 0);
    reset_mid_dram();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 6) a = AW'(16'h00FC + $urandom_range(0, 11));
      else                          a = AW'($urandom_range(0, 16'hFFFF));
      sel = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) ignored_pulse(a);
      do_req(a, 16'($urandom), (sel != 1), (sel == 1 || sel == 2),
             16'($urandom), $urandom_range(0, 4));
    end

    repeat (3) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit (%0d compared / %0d mismatched)", n_cmp, n_err);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_io_router.md
# mem_io_router

Parametrised memory-request router between the CPU memory port and the SDRAM `mem_driver`. It decodes each accepted request against a configurable memory-mapped I/O window. The window holds `IO_OUT_COUNT` read/write output registers (e.g. seven-segment value, LEDs) and `IO_IN_COUNT` read-only input ports; every other address is forwarded to the DRAM driver. A small state machine tracks the outstanding transaction so that only one request is in flight and completion is reported exactly once.

## Interface
- `ADDR_WIDTH`, 16, request address width
- `DATA_WIDTH`, 16, data width
- `IO_BASE`, 'h0100, first address of the I/O window
- `IO_OUT_COUNT`, 4, number of R/W output registers, at `IO_BASE` .. `IO_BASE+IO_OUT_COUNT-1` (≥1)
- `IO_IN_COUNT`, 2, number of read-only input ports, immediately after the output registers (≥0)
- `IO_RESET_VAL`, 'h0100, reset value of every output register
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: asynchronous, active-low reset
- `mem_addr` in `ADDR_WIDTH`: request address
- `mem_data_in` in `DATA_WIDTH`: write data
- `mem_r_en`, `mem_w_en` in 1: read / write request
- `mem_rdy` out 1: router can accept a request this cycle
- `mem_cplt` out 1: one-cycle completion pulse
- `mem_data_out` out `DATA_WIDTH`: read data, valid while `mem_cplt`=1
- `dram_r_en`, `dram_w_en` out 1: request to `mem_driver`
- `dram_rdy`, `dram_cplt` in 1: `mem_driver` ready / completion
- `dram_data_out` in `DATA_WIDTH`: `mem_driver` read data
- `io_out` out `IO_OUT_COUNT*DATA_WIDTH`: output registers; register k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- `io_wr_stb` out `IO_OUT_COUNT`: one-cycle pulse when register k is written
- `io_in` in `IO_IN_COUNT*DATA_WIDTH`: input ports, packed the same way

## Operation
- States: IDLE, DRAM_WAIT, IO_RESP.
- `mem_rdy` = (state==IDLE) && `dram_rdy`. It is combinational.
- Accept: a request is accepted on a rising edge where `mem_rdy`=1 and (`mem_r_en` or `mem_w_en`). Requests made while `mem_rdy`=0 are ignored and are not queued.
- If `mem_r_en` and `mem_w_en` are both high, the request is a read and the write is dropped.
- Decode: offset = `mem_addr` − `IO_BASE`.
  - Out-register hit: `mem_addr` ≥ `IO_BASE` and offset < `IO_OUT_COUNT`.
  - In-port hit: `IO_OUT_COUNT` ≤ offset < `IO_OUT_COUNT+IO_IN_COUNT`.
  - Everything else, including addresses below `IO_BASE`, is a DRAM request.
- DRAM request:
  - `dram_r_en`/`dram_w_en` mirror `mem_r_en`/`mem_w_en` combinationally in the accept cycle only, after read priority is applied.
  - Next state is DRAM_WAIT.
  - `mem_cplt` = `dram_cplt` and `mem_data_out` = `dram_data_out` while in DRAM_WAIT. On `dram_cplt` the state returns to IDLE.
- I/O request:
  - `dram_r_en` and `dram_w_en` stay 0.
  - Out-register write: the register is loaded with `mem_data_in` at the accept edge, and `io_wr_stb[k]` is high for the following cycle.
  - Read: the response register captures either the register value or `io_in` (sampled at the accept edge).
  - A write to an in-port offset completes normally but has no effect.
  - Next state is IO_RESP.
- IO_RESP lasts exactly one cycle. During it `mem_cplt`=1; `mem_data_out` = captured value for reads and 0 for writes. The state then returns to IDLE.
- Outside DRAM_WAIT/IO_RESP, `mem_cplt`=0 and `mem_data_out`=0.
- Reset (asynchronous, any state, including mid-transaction):
  - state → IDLE
  - every `io_out` register → `IO_RESET_VAL`
  - `io_wr_stb` = 0, response register = 0
  - an in-flight DRAM completion arriving after reset is ignored

## Timing
- I/O access: accept at edge N; `mem_cplt` high in cycle N+1; `mem_rdy` high again in N+2 if `dram_rdy`=1. Latency is 1 cycle.
- `io_out` updates at the accept edge, so it is visible in cycle N+1, together with `io_wr_stb`.
- DRAM access: latency is that of `mem_driver`. `mem_cplt` is the same cycle as `dram_cplt`; `mem_rdy` is earliest in the cycle after.
- Back-to-back I/O accesses achieve one access per 2 cycles.
- `dram_r_en`/`dram_w_en` are never asserted outside IDLE.

## Test plan
- Reset release with `IO_OUT_COUNT`=4: all `io_out` words = 'h0100, `mem_rdy` follows `dram_rdy`, `mem_cplt`=0.
- Write 'hBEEF to 'h0102: `io_out[2]`='hBEEF and `io_wr_stb`='b0100 one cycle after accept. No `dram_w_en` is issued. `mem_cplt` pulses once. A read of 'h0102 returns 'hBEEF with a 1-cycle completion.
- `io_in` word 1 = 'h1234; read 'h0105 → 'h1234. A write to 'h0105 completes, and `io_out` and `io_in` are unchanged.
- Read 'h0200 and 'h00FF: `dram_r_en` is asserted in the accept cycle only, and `mem_rdy`=0 until completion. A delayed `dram_cplt` with data 'hCAFE gives `mem_cplt`=1 and `mem_data_out`='hCAFE in that cycle.
- Simultaneous `mem_r_en`/`mem_w_en` to 'h0101: handled as a read, and the register is unchanged. Request pulses while `mem_rdy`=0 produce no DRAM or I/O activity.
- Assert `rst` low during DRAM_WAIT: state returns to IDLE, registers return to 'h0100, and a later `dram_cplt` produces no `mem_cplt`.
